rca8_multibyte_add_seq: RTL and testbench

//  - Sequencer that computes wide additions (8*NBYTES bits) through one shared 8-bit ripple-carry adder (RCA_8).
//  - Processes one byte slice per cycle, LSB first; a carry register links the slices.
//  - Start/busy/done handshake; sits between a host FSM and the RCA_8 datapath.

---
 rtl/rca8_multibyte_add_seq.sv | 131 +++++++++++++
 tb/tb_rca8_multibyte_add_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rca8_multibyte_add_seq.sv
// Byte-serial wide adder: one shared 8-bit ripple-carry adder walks NBYTES slices, LSB first.
// Optional build macro ADDSEQ_SUBTRACT_EN adds a 'sub' port for a - b.

module rca8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] c;
  assign c[0] = ci;
  rca8_fa u_fa[7:0] (.a(a), .b(b), .ci(c[7:0]), .s(s), .co(c[8:1]));
  assign co = c[8];
endmodule

module rca8_multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef ADDSEQ_SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [NBYTES-1:0][7:0] a;
    logic [NBYTES-1:0][7:0] b;
  } op_t;

  state_t                 state, state_n;
  op_t                    op_q;
  logic [IW-1:0]          idx;
  logic                   carry;
  logic [NBYTES-1:0][7:0] sum_q;
  logic                   accept, last;
  logic [7:0]             rca_a, rca_b, rca_s;
  logic                   rca_co, carry_init;

  assign last = (idx == IW'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ADDSEQ_SUBTRACT_EN
  logic sub_q;
  // Subtract is a + ~b + 1: invert each B slice and seed the carry with 1.
  assign rca_b      = op_q.b[idx] ^ {8{sub_q}};
  assign carry_init = sub ? 1'b1 : cin;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  assign rca_b      = op_q.b[idx];
  assign carry_init = cin;
`endif

  assign rca_a = op_q.a[idx];

  rca8 u_rca8 (.a(rca_a), .b(rca_b), .ci(carry), .s(rca_s), .co(rca_co));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum_q <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_q  <= '{a: a, b: b};
      idx   <= '0;
      carry <= carry_init;
    end else if (state == RUN) begin
      sum_q[idx] <= rca_s;
      carry      <= rca_co;
      // idx parks on the top slice rather than wrapping.
      if (last) cout <= rca_co;
      else      idx  <= idx + IW'(1);
    end
  end

  assign sum = sum_q;
endmodule

// File: tb/tb_rca8_multibyte_add_seq.sv
// Bench for rca8_multibyte_add_seq: directed table, handshake/reset sequences, random ops vs arithmetic model.
module tb_rca8_multibyte_add_seq;
  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [31:0] a, b, sum;
  logic        busy, done, cout;
  logic        start2, cin2;
  logic [15:0] a2, b2, sum2;
  logic        busy2, done2, cout2;
`ifdef ADDSEQ_SUBTRACT_EN
  logic        sub, sub2;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rca8_multibyte_add_seq #(.NBYTES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDSEQ_SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout));

  rca8_multibyte_add_seq #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef ADDSEQ_SUBTRACT_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] esum;
    logic        ecout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, 33 bits so the top carry is kept.
  function automatic logic [32:0] model(input logic [31:0] x, y, input logic c, s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 33'd1;
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  task automatic drive(input logic [31:0] ta, tb, input logic tc, ts);
    a = ta; b = tb; cin = tc;
`ifdef ADDSEQ_SUBTRACT_EN
    sub = ts;
`endif
  endtask

  // Wait for done (bounded); returns the cycle number relative to start's cycle.
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op(input string nm, input logic [31:0] ta, tb, input logic tc, ts,
                    input logic [31:0] esum, input logic ecout);
    int cyc;
    @(negedge clk);
    drive(ta, tb, tc, ts);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy1"}, busy, 1'b1);
    wait_done(1, cyc);
    chk({nm, "_lat"}, cyc, 5);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    chk({nm, "_sum"}, sum, esum);
    chk({nm, "_cout"}, cout, ecout);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic        rc, rs;
    int          cyc;
    logic        seen;

    vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0});
    vecs.push_back('{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0});
`ifdef ADDSEQ_SUBTRACT_EN
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
    sub2 = 1'b0;
`endif

    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    a2 = '0; b2 = '0; cin2 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
         vecs[i].esum, vecs[i].ecout);

    // Async reset with no clock edge clears held results.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", sum, 32'h0);
    chk("arst_cout", cout, 1'b0);
    chk("arst_busy", busy, 1'b0);
    #1 rst = 1'b0;

    // Start pulsed mid-RUN with new operands is ignored.
    @(negedge clk);
    drive(32'h01020304, 32'h10203040, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    drive(32'hDEADBEEF, 32'h55555555, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3, cyc);
    chk("hs1_lat", cyc, 5);
    chk("hs1_sum", sum, 32'h11223344);
    @(negedge clk);
    chk("hs1_no_requeue", busy, 1'b0);

    // Start held high through done: back-to-back op.
    @(negedge clk);
    drive(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    drive(32'h00000001, 32'h00000002, 1'b0, 1'b0);
    wait_done(1, cyc);
    chk("hs2_lat1", cyc, 5);
    chk("hs2_sum1", sum, 32'h00000030);
    @(negedge clk);
    start = 1'b0;
    chk("hs2_busy_next", busy, 1'b1);
    wait_done(1, cyc);
    chk("hs2_lat2", cyc, 5);
    chk("hs2_sum2", sum, 32'h00000003);
    chk("hs2_cout2", cout, 1'b0);

    // Reset after two slices aborts with no done pulse.
    @(negedge clk);
    drive(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_sum", sum, 32'h0);
    chk("mid_cout", cout, 1'b0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("mid_no_done", seen, 1'b0);
    op("mid_fresh", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUBTRACT_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (i < 4) rb = ~ra;
      r = model(ra, rb, rc, rs);
      op($sformatf("rnd%0d", i), ra, rb, rc, rs, r[31:0], r[32]);
    end

    // NBYTES=2 instance.
    @(negedge clk);
    a2 = 16'hFFFF; b2 = 16'h0001; cin2 = 1'b0; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("n2_lat", cyc, 3);
    chk("n2_sum", sum2, 16'h0000);
    chk("n2_cout", cout2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
